// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph constants, widths and FSM state type for the 7-segment address decoder
package seg7_pkg;
  localparam int SEG_W  = 7;
  localparam int ADDR_W = 5;
  localparam logic [SEG_W-1:0] CHR_0 = 7'h40;
  localparam logic [SEG_W-1:0] CHR_1 = 7'h79;
  localparam logic [SEG_W-1:0] CHR_2 = 7'h24;
  localparam logic [SEG_W-1:0] CHR_3 = 7'h30;
  localparam logic [SEG_W-1:0] CHR_4 = 7'h19;
  localparam logic [SEG_W-1:0] CHR_5 = 7'h12;
  localparam logic [SEG_W-1:0] CHR_6 = 7'h02;
  localparam logic [SEG_W-1:0] CHR_7 = 7'h58;
  localparam logic [SEG_W-1:0] CHR_8 = 7'h00;
  localparam logic [SEG_W-1:0] CHR_9 = 7'h10;
  localparam logic [SEG_W-1:0] CHR_A = 7'h08;
  localparam logic [SEG_W-1:0] CHR_B = 7'h03;
  localparam logic [SEG_W-1:0] CHR_C = 7'h46;
  localparam logic [SEG_W-1:0] CHR_D = 7'h21;
  localparam logic [SEG_W-1:0] CHR_E = 7'h06;
  localparam logic [SEG_W-1:0] CHR_F = 7'h0E;
  localparam logic [SEG_W-1:0] BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH [16] = '{CHR_0, CHR_1, CHR_2, CHR_3, CHR_4, CHR_5, CHR_6, CHR_7,
                                              CHR_8, CHR_9, CHR_A, CHR_B, CHR_C, CHR_D, CHR_E, CHR_F};
  typedef enum logic {TRACK, PRESENT} state_t;
endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: combinational decode of one active-low segment pattern to a hex nibble
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic             legal,
  output logic             is_blank,
  output logic [3:0]       nibble
);
  assign is_blank = seg == BLANK;
  always_comb begin
    legal  = 1'b0;
    nibble = '0;
    for (int i = 0; i < 16; i++)
      if (seg == GLYPH[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
  end
endmodule

// File: rtl/seg7_address_decoder.sv
// seg7_address_decoder: debounces a two-digit segment pair and offers the decoded address on valid/ready
module seg7_address_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEG_W-1:0]  seg1,
  input  logic [SEG_W-1:0]  seg0,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              blank,
  output logic              err
);
  logic [2*SEG_W-1:0] sample, prev_q, prev_d, last_rep_q, last_rep_d;
  logic [7:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic valid_q, valid_d, blank_q, blank_d, err_q, err_d;
  state_t state_q, state_d;
  logic hi_legal, hi_blank, lo_legal, lo_blank, match, qualify, is_addr, is_blank;
  logic [3:0] hi_nib, lo_nib;

  seg7_to_hex u_hi (.seg(seg1), .legal(hi_legal), .is_blank(hi_blank), .nibble(hi_nib));
  seg7_to_hex u_lo (.seg(seg0), .legal(lo_legal), .is_blank(lo_blank), .nibble(lo_nib));

  assign sample   = {seg1, seg0};
  assign match    = sample == prev_q;
  assign is_addr  = hi_legal && lo_legal && hi_nib[3:1] == 3'd0;
  assign is_blank = hi_blank && lo_blank;
  // the edge that brings the run to STABLE_CYCLES identical samples
  assign qualify  = state_q == TRACK && match && cnt_q == 8'(STABLE_CYCLES - 2) && sample != last_rep_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    last_rep_d = last_rep_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    blank_d    = blank_q;
    err_d      = 1'b0;
    if (state_q == TRACK) begin
      prev_d = sample;
      cnt_d  = !match ? 8'd0 : (cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1);
      if (qualify) begin
        last_rep_d = sample;
        blank_d    = is_blank;
        err_d      = !is_addr && !is_blank;
        if (is_addr) begin
          addr_d  = {hi_nib[0], lo_nib};
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
    end else if (addr_ready) begin
      state_d = TRACK;
      valid_d = 1'b0;
      cnt_d   = 8'd0;
      prev_d  = sample;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= TRACK;
      cnt_q      <= 8'd0;
      prev_q     <= '1;
      last_rep_q <= '1;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      blank_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      last_rep_q <= last_rep_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
    end

  assign addr_out   = addr_q;
  assign addr_valid = valid_q;
  assign blank      = blank_q;
  assign err        = err_q;
endmodule

// File: tb/tb_seg7_address_decoder.sv
// tb_seg7_address_decoder: directed scenarios plus random stimulus against a run-length reference model
module tb_seg7_address_decoder;
  localparam int STABLE = 4;
  logic clk = 1'b0, reset = 1'b1, addr_ready = 1'b1;
  logic [6:0] seg1 = 7'h79, seg0 = 7'h02;
  logic [4:0] addr_out;
  logic addr_valid, blank, err;
  int n_chk = 0, n_pass = 0;
  logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [13:0] m_last, m_rep;
  int m_run, m_addr;
  bit m_valid, m_blank, m_err;

  seg7_address_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .reset(reset), .seg1(seg1), .seg0(seg0), .addr_out(addr_out),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .blank(blank), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic int gidx(input logic [6:0] s);
    if (s == 7'h7F) return 16;
    for (int i = 0; i < 16; i++) if (gl[i] == s) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_last = 14'h3FFF; m_rep = 14'h3FFF; m_run = 1;
    m_addr = 0; m_valid = 0; m_blank = 1; m_err = 0;
  endtask

  task automatic step();
    logic [13:0] s;
    int hi, lo;
    s = {seg1, seg0};
    m_err = 0;
    if (m_valid) begin
      if (addr_ready) begin m_valid = 0; m_last = s; m_run = 1; end
    end else begin
      m_run = (s == m_last) ? m_run + 1 : 1;
      m_last = s;
      if (m_run == STABLE && s != m_rep) begin
        m_rep = s;
        hi = gidx(seg1);
        lo = gidx(seg0);
        if (hi >= 0 && hi <= 1 && lo >= 0 && lo <= 15) begin
          m_addr = hi * 16 + lo; m_valid = 1; m_blank = 0;
        end else if (hi == 16 && lo == 16) m_blank = 1;
        else begin m_err = 1; m_blank = 0; end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    step();
    #1;
    check("valid", addr_valid, m_valid);
    if (m_valid) check("addr", addr_out, m_addr);
    check("blank", blank, m_blank);
    check("err", err, m_err);
  endtask

  task automatic cycs(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  function automatic logic [6:0] pick(input bit upper);
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return upper ? gl[$urandom_range(0, 1)] : gl[$urandom_range(0, 15)];
    if (r < 8) return gl[$urandom_range(0, 15)];
    if (r < 9) return 7'h7F;
    return 7'($urandom);
  endfunction

  initial begin
    int seen_v, seen_e, n_err;
    #12;
    check("rst_valid", addr_valid, 0);
    check("rst_addr", addr_out, 0);
    check("rst_blank", blank, 1);
    check("rst_err", err, 0);
    m_reset();
    reset = 1'b0;
    cycs(4);
    check("t1_valid", addr_valid, 1);
    check("t1_addr", addr_out, 5'h16);
    cycs(6);
    addr_ready = 1'b0; seg1 = 7'h40; seg0 = 7'h06;
    cycs(4);
    check("t2_valid", addr_valid, 1);
    check("t2_addr", addr_out, 5'h0E);
    seg1 = 7'h79; seg0 = 7'h79;
    cycs(10);
    check("t2_hold", addr_out, 5'h0E);
    addr_ready = 1'b1;
    cycs(4);
    check("t2_next_valid", addr_valid, 1);
    check("t2_next_addr", addr_out, 5'h11);
    seg1 = 7'h40; seen_v = 0; seen_e = 0;
    for (int i = 0; i < 30; i++) begin
      seg0 = (i / 3) % 2 ? 7'h79 : 7'h40;
      cyc();
      seen_v += addr_valid; seen_e += err;
    end
    check("t3_no_valid", seen_v, 0);
    check("t3_no_err", seen_e, 0);
    seg1 = 7'h24; seg0 = 7'h40; seen_v = 0; n_err = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      seen_v += addr_valid; n_err += err;
    end
    check("t4_err_once", n_err, 1);
    check("t4_no_valid", seen_v, 0);
    check("t4_blank", blank, 0);
    addr_ready = 1'b0; seg1 = 7'h40; seg0 = 7'h40;
    cycs(4);
    check("t5_first", addr_valid, 1);
    addr_ready = 1'b1;
    cyc();
    seg1 = 7'h7F; seg0 = 7'h7F;
    cycs(6);
    check("t5_blank", blank, 1);
    addr_ready = 1'b0; seg1 = 7'h40; seg0 = 7'h40;
    cycs(4);
    check("t5_second", addr_valid, 1);
    check("t5_second_addr", addr_out, 0);
    check("t5_blank_clr", blank, 0);
    #2 reset = 1'b1;
    #1 check("t5_async_drop", addr_valid, 0);
    m_reset();
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 400; k++) begin
      int hold;
      seg1 = pick(1'b1);
      seg0 = pick(1'b0);
      if ($urandom_range(0, 7) == 0) begin seg1 = 7'h7F; seg0 = 7'h7F; end
      hold = $urandom_range(1, 8);
      for (int j = 0; j < hold; j++) begin
        addr_ready = $urandom_range(0, 9) < 7;
        cyc();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
